fifo_ctrl: RTL and testbench

Control front-end for the 8-entry x 9-bit pointer-addressed FIFO storage block. Accepts producer write requests and consumer read/drop requests, and drives the storage's write-enable, read-enable, pointer-increment and pointer-clear inputs. Tracks occupancy and exports full/empty/almost-full, a read-data-valid strobe aligned to the storage's registered DataOut, and sticky overflow/underflow errors. Sits between the datapath producer/consumer and the storage; the 9-bit data bus bypasses this block.

---
 rtl/fifo_ctrl_if.sv | 31 +++
 rtl/fifo_ctrl.sv | 53 +++++
 tb/tb_fifo_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/handshake, storage-control and status signals of the FIFO controller
interface fifo_ctrl_if #(parameter int CW = 4);
  logic wr_req;
  logic rd_req;
  logic drop_req;
  logic flush;
  logic wden;
  logic rden;
  logic rdinc;
  logic wrinc;
  logic RdPtrClr;
  logic WrPtrClr;
  logic wr_ack;
  logic rd_valid;
  logic [CW-1:0] count;
  logic full;
  logic empty;
  logic almost_full;
  logic overflow;
  logic underflow;
  modport slave (
    input  wr_req, rd_req, drop_req, flush,
    output wden, rden, rdinc, wrinc, RdPtrClr, WrPtrClr, wr_ack, rd_valid,
           count, full, empty, almost_full, overflow, underflow
  );
  modport master (
    output wr_req, rd_req, drop_req, flush,
    input  wden, rden, rdinc, wrinc, RdPtrClr, WrPtrClr, wr_ack, rd_valid,
           count, full, empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: control front-end for an 8x9 pointer-addressed FIFO storage block
module fifo_ctrl #(
  parameter int DEPTH    = 8,
  parameter int CW       = 4,
  parameter int AF_LEVEL = 6
) (
  input logic        clk,
  input logic        rst,
  fifo_ctrl_if.slave bus
);
  typedef enum logic {CLEAR, RUN} state_e;
  state_e        state_q;
  logic [CW-1:0] count_q, count_d;
  logic          rd_valid_q, overflow_q, underflow_q;
  logic          full, empty, run, act;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign run   = (state_q == RUN) & ~rst;
  assign act   = run & ~bus.flush;
  // rd_req wins over drop_req so the pointer never advances twice in one cycle
  assign bus.wden        = act & bus.wr_req & ~full;
  assign bus.rden        = act & bus.rd_req & ~empty;
  assign bus.rdinc       = act & bus.drop_req & ~bus.rd_req & ~empty;
  assign bus.wrinc       = 1'b0;
  assign bus.RdPtrClr    = (state_q == CLEAR) & ~rst;
  assign bus.WrPtrClr    = (state_q == CLEAR) & ~rst;
  assign bus.wr_ack      = bus.wden;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = count_q >= CW'(AF_LEVEL);
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  always_comb
    count_d = (run & bus.flush) ? '0
            : count_q + CW'(bus.wden) - CW'(bus.rden) - CW'(bus.rdinc);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= bus.flush ? CLEAR : RUN;
      count_q     <= count_d;
      rd_valid_q  <= bus.rden;
      overflow_q  <= overflow_q | (act & bus.wr_req & full);
      underflow_q <= underflow_q | (act & (bus.rd_req | bus.drop_req) & empty);
    end
  end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scenario tasks plus a storage model and data-order scoreboard
module tb_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [8:0] din = '0;
  int errors = 0;
  int checks = 0;
  fifo_ctrl_if #(.CW(4)) bus ();
  fifo_ctrl #(.DEPTH(8), .CW(4), .AF_LEVEL(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  logic [8:0] mem [0:7];
  logic [2:0] wptr = '0, rptr = '0;
  logic [8:0] dout = '0, exp_rd = '0;
  logic       pending = 1'b0;
  logic [8:0] q [$];

  // storage model and scoreboard, evaluated mid-cycle when enables are stable
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      pending = 1'b0;
    end else begin
      checks++;
      if (bus.rd_valid !== pending) begin
        errors++;
        $display("FAIL rd_valid_timing: got %b want %b", bus.rd_valid, pending);
      end
      if (bus.rd_valid && pending) begin
        checks++;
        if (dout !== exp_rd) begin
          errors++;
          $display("FAIL read_data: got %h want %h", dout, exp_rd);
        end
      end
      pending = bus.rden;
      if (bus.rden) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rden_on_empty_model: got rden=1 want 0");
        end else exp_rd = q.pop_front();
        dout = mem[rptr];
        rptr = rptr + 3'd1;
      end
      if (bus.rdinc) begin
        if (q.size() != 0) void'(q.pop_front());
        rptr = rptr + 3'd1;
      end
      if (bus.WrPtrClr) wptr = '0;
      if (bus.RdPtrClr) rptr = '0;
      if (bus.wden) begin
        mem[wptr] = din;
        wptr = wptr + 3'd1;
        q.push_back(din);
      end
      if (bus.flush && !bus.RdPtrClr) q.delete();
    end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task idle;
    bus.wr_req = 0; bus.rd_req = 0; bus.drop_req = 0; bus.flush = 0;
  endtask

  task do_reset;
    idle();
    rst = 1; tick();
    rst = 0; tick();
  endtask

  task wr(input logic [8:0] d);
    din = d; bus.wr_req = 1; tick(); bus.wr_req = 0;
  endtask

  task rd;
    bus.rd_req = 1; tick(); bus.rd_req = 0;
  endtask

  task test_reset;
    idle(); rst = 1; bus.wr_req = 1; bus.rd_req = 1;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (bus.wden !== 0 || bus.rden !== 0 || bus.rdinc !== 0 || bus.RdPtrClr !== 0 || bus.WrPtrClr !== 0 || bus.wrinc !== 0) begin
      errors++;
      $display("FAIL reset_ctrl: got wden=%b rden=%b rdinc=%b rclr=%b wclr=%b wrinc=%b want all 0",
               bus.wden, bus.rden, bus.rdinc, bus.RdPtrClr, bus.WrPtrClr, bus.wrinc);
    end
    checks++;
    if (bus.count !== 0 || bus.empty !== 1 || bus.full !== 0 || bus.almost_full !== 0 || bus.rd_valid !== 0 || bus.overflow !== 0 || bus.underflow !== 0) begin
      errors++;
      $display("FAIL reset_status: got cnt=%0d e=%b f=%b af=%b rv=%b ov=%b un=%b want 0 1 0 0 0 0 0",
               bus.count, bus.empty, bus.full, bus.almost_full, bus.rd_valid, bus.overflow, bus.underflow);
    end
    tick();
    rst = 0; bus.rd_req = 0;
    @(negedge clk);
    checks++;
    if (bus.RdPtrClr !== 1 || bus.WrPtrClr !== 1 || bus.wr_ack !== 0) begin
      errors++;
      $display("FAIL clear_cycle: got rclr=%b wclr=%b ack=%b want 1 1 0", bus.RdPtrClr, bus.WrPtrClr, bus.wr_ack);
    end
    tick(); bus.wr_req = 0;
    @(negedge clk);
    checks++;
    if (bus.RdPtrClr !== 0 || bus.count !== 0) begin
      errors++;
      $display("FAIL run_entry: got rclr=%b cnt=%0d want 0 0", bus.RdPtrClr, bus.count);
    end
  endtask

  task test_fill;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      din = 9'(i * 37 + 5); bus.wr_req = 1;
      @(negedge clk);
      checks++;
      if (bus.wr_ack !== 1 || bus.count !== 4'(i) || bus.almost_full !== (i >= 6) || bus.full !== 0) begin
        errors++;
        $display("FAIL fill[%0d]: got ack=%b cnt=%0d af=%b full=%b want 1 %0d %b 0",
                 i, bus.wr_ack, bus.count, bus.almost_full, bus.full, i, i >= 6);
      end
      tick();
    end
    din = 9'h1EE;
    @(negedge clk);
    checks++;
    if (bus.full !== 1 || bus.count !== 8 || bus.wden !== 0) begin
      errors++;
      $display("FAIL write_on_full: got full=%b cnt=%0d wden=%b want 1 8 0", bus.full, bus.count, bus.wden);
    end
    tick(); bus.wr_req = 0;
    @(negedge clk);
    checks++;
    if (bus.overflow !== 1 || bus.count !== 8) begin
      errors++;
      $display("FAIL overflow_set: got ov=%b cnt=%0d want 1 8", bus.overflow, bus.count);
    end
    for (int i = 0; i < 8; i++) rd();
    tick();
    checks++;
    if (bus.overflow !== 1 || bus.empty !== 1) begin
      errors++;
      $display("FAIL overflow_sticky: got ov=%b empty=%b want 1 1", bus.overflow, bus.empty);
    end
  endtask

  task test_read;
    do_reset();
    wr(9'h101); wr(9'h0AA); wr(9'h1FF);
    for (int i = 0; i < 3; i++) begin
      bus.rd_req = 1;
      @(negedge clk);
      checks++;
      if (bus.rden !== 1) begin
        errors++;
        $display("FAIL read[%0d]: got rden=%b want 1", i, bus.rden);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (bus.rden !== 0 || bus.empty !== 1) begin
      errors++;
      $display("FAIL read_on_empty: got rden=%b empty=%b want 0 1", bus.rden, bus.empty);
    end
    tick(); bus.rd_req = 0;
    @(negedge clk);
    checks++;
    if (bus.underflow !== 1) begin
      errors++;
      $display("FAIL underflow_set: got %b want 1", bus.underflow);
    end
  endtask

  task test_simultaneous;
    do_reset();
    for (int i = 0; i < 4; i++) wr(9'(i + 9'h40));
    din = 9'h055; bus.wr_req = 1; bus.rd_req = 1;
    @(negedge clk);
    checks++;
    if (bus.wden !== 1 || bus.rden !== 1) begin
      errors++;
      $display("FAIL wr_rd_mid: got wden=%b rden=%b want 1 1", bus.wden, bus.rden);
    end
    tick(); idle();
    @(negedge clk);
    checks++;
    if (bus.count !== 4) begin
      errors++;
      $display("FAIL wr_rd_mid_count: got %0d want 4", bus.count);
    end
    for (int i = 0; i < 4; i++) rd();
    tick();
    do_reset();
    din = 9'h077; bus.wr_req = 1; bus.rd_req = 1;
    @(negedge clk);
    checks++;
    if (bus.wden !== 1 || bus.rden !== 0) begin
      errors++;
      $display("FAIL wr_rd_empty: got wden=%b rden=%b want 1 0", bus.wden, bus.rden);
    end
    tick(); idle();
    @(negedge clk);
    checks++;
    if (bus.count !== 1 || bus.underflow !== 1) begin
      errors++;
      $display("FAIL wr_rd_empty_after: got cnt=%0d un=%b want 1 1", bus.count, bus.underflow);
    end
    do_reset();
    for (int i = 0; i < 8; i++) wr(9'(i + 9'h80));
    din = 9'h0FF; bus.wr_req = 1; bus.rd_req = 1;
    @(negedge clk);
    checks++;
    if (bus.wden !== 0 || bus.rden !== 1) begin
      errors++;
      $display("FAIL wr_rd_full: got wden=%b rden=%b want 0 1", bus.wden, bus.rden);
    end
    tick(); idle();
    @(negedge clk);
    checks++;
    if (bus.count !== 7 || bus.overflow !== 1) begin
      errors++;
      $display("FAIL wr_rd_full_after: got cnt=%0d ov=%b want 7 1", bus.count, bus.overflow);
    end
    for (int i = 0; i < 7; i++) rd();
    tick();
  endtask

  task test_drop;
    do_reset();
    for (int i = 0; i < 5; i++) wr(9'(i * 3 + 9'h10));
    bus.drop_req = 1;
    @(negedge clk);
    checks++;
    if (bus.rdinc !== 1 || bus.rden !== 0) begin
      errors++;
      $display("FAIL drop: got rdinc=%b rden=%b want 1 0", bus.rdinc, bus.rden);
    end
    tick(); bus.rd_req = 1;
    @(negedge clk);
    checks++;
    if (bus.count !== 4 || bus.rdinc !== 0 || bus.rden !== 1) begin
      errors++;
      $display("FAIL drop_with_read: got cnt=%0d rdinc=%b rden=%b want 4 0 1", bus.count, bus.rdinc, bus.rden);
    end
    tick(); idle();
    @(negedge clk);
    checks++;
    if (bus.count !== 3 || bus.underflow !== 0) begin
      errors++;
      $display("FAIL drop_after: got cnt=%0d un=%b want 3 0", bus.count, bus.underflow);
    end
    for (int i = 0; i < 3; i++) rd();
    tick();
  endtask

  task test_flush;
    do_reset();
    rd();
    for (int i = 0; i < 7; i++) wr(9'(i + 9'h120));
    bus.rd_req = 1; tick(); bus.rd_req = 0;
    bus.flush = 1; bus.wr_req = 1; din = 9'h033;
    @(negedge clk);
    checks++;
    if (bus.wden !== 0 || bus.rden !== 0 || bus.count !== 6) begin
      errors++;
      $display("FAIL flush_cycle: got wden=%b rden=%b cnt=%0d want 0 0 6", bus.wden, bus.rden, bus.count);
    end
    tick(); bus.flush = 0;
    @(negedge clk);
    checks++;
    if (bus.RdPtrClr !== 1 || bus.WrPtrClr !== 1 || bus.count !== 0 || bus.wr_ack !== 0 || bus.underflow !== 1 || bus.overflow !== 0) begin
      errors++;
      $display("FAIL flush_clear: got rclr=%b wclr=%b cnt=%0d ack=%b un=%b ov=%b want 1 1 0 0 1 0",
               bus.RdPtrClr, bus.WrPtrClr, bus.count, bus.wr_ack, bus.underflow, bus.overflow);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.wr_ack !== 1) begin
      errors++;
      $display("FAIL flush_resume: got ack=%b want 1", bus.wr_ack);
    end
    tick(); bus.wr_req = 0;
    rd(); tick();
  endtask

  task test_wrap;
    int cnt;
    logic w, r;
    do_reset();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      w = (i < 14) && (i % 4 != 3);
      r = (i % 3 != 0);
      din = 9'($urandom); bus.wr_req = w; bus.rd_req = r;
      @(negedge clk);
      checks++;
      if (bus.wr_ack !== (w && cnt < 8) || bus.rden !== (r && cnt > 0)) begin
        errors++;
        $display("FAIL wrap[%0d]: got ack=%b rden=%b want %b %b", i, bus.wr_ack, bus.rden, w && cnt < 8, r && cnt > 0);
      end
      cnt = cnt + int'(w && cnt < 8) - int'(r && cnt > 0);
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if (bus.count !== 4'(cnt)) begin
      errors++;
      $display("FAIL wrap_count: got %0d want %0d", bus.count, cnt);
    end
    for (int i = 0; i < cnt; i++) rd();
    tick();
  endtask

  task test_midstream_reset;
    do_reset();
    rd();
    wr(9'h011); wr(9'h022); wr(9'h033);
    rst = 1; bus.wr_req = 1;
    @(negedge clk);
    checks++;
    if (bus.wden !== 0 || bus.RdPtrClr !== 0) begin
      errors++;
      $display("FAIL rst_gate: got wden=%b rclr=%b want 0 0", bus.wden, bus.RdPtrClr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.count !== 0 || bus.underflow !== 0 || bus.overflow !== 0 || bus.empty !== 1) begin
      errors++;
      $display("FAIL rst_mid: got cnt=%0d un=%b ov=%b empty=%b want 0 0 0 1", bus.count, bus.underflow, bus.overflow, bus.empty);
    end
    tick(); rst = 0;
    @(negedge clk);
    checks++;
    if (bus.RdPtrClr !== 1 || bus.wr_ack !== 0) begin
      errors++;
      $display("FAIL rst_clear_cycle: got rclr=%b ack=%b want 1 0", bus.RdPtrClr, bus.wr_ack);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.wr_ack !== 1) begin
      errors++;
      $display("FAIL rst_resume: got ack=%b want 1", bus.wr_ack);
    end
    tick(); idle();
    rd(); tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_read();
    test_simultaneous();
    test_drop();
    test_flush();
    test_wrap();
    test_midstream_reset();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
